// File: rtl/ntru_modp_pack.sv
// Center-lifts mod-q coefficients, reduces them to trits mod 3 and packs the
// trits 2 bits each into AXI4-Stream words, flagging frames whose length is not N.
module ntru_modp_pack #(
  parameter int D_WIDTH = 32,
  parameter int N       = 11,
  parameter int q       = 2048,
  parameter int p       = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [D_WIDTH-1:0] din_tdata,
  input  logic               din_tvalid,
  input  logic               din_tlast,
  output logic               din_tready,
  output logic [D_WIDTH-1:0] dout_tdata,
  output logic               dout_tvalid,
  output logic               dout_tlast,
  input  logic               dout_tready,
  output logic               frame_err
);

  localparam int QW   = $clog2(q - 1);
  localparam int TPW  = D_WIDTH / 2;
  localparam int SW   = $clog2(TPW);
  localparam int CW   = $clog2(N + 1);
  localparam int EW   = 2 * ((QW + 1) / 2);
  localparam int HALF = q / 2;

  typedef enum logic {FILL = 1'b0, SEND = 1'b1} state_t;

  state_t             state_r;
  logic [SW-1:0]      slot_r;
  logic [CW-1:0]      coef_cnt_r;
  logic [D_WIDTH-1:0] pack_r;

  logic [QW-1:0]      v_s;
  logic               neg_s;
  logic [QW-1:0]      mag_s;
  logic [1:0]         rem_s;
  logic [1:0]         trit_s;
  logic [CW-1:0]      coef_inc_s;
  logic               last_beat_s;
  logic               close_s;
  logic               len_bad_s;
  logic               accept_s;
  logic [D_WIDTH-1:0] pack_ins_s;
  logic               unused_s;

  // Sum of the four base-4 digits of an 8-bit value (4 == 1 mod 3).
  function automatic logic [7:0] fold4(input logic [7:0] a);
    return 8'(a[1:0]) + 8'(a[3:2]) + 8'(a[5:4]) + 8'(a[7:6]);
  endfunction

  // Multiplier-free m mod 3: base-4 digit sums shrink the value, then at most two subtracts.
  function automatic logic [1:0] mod3(input logic [QW-1:0] m);
    logic [EW-1:0] ext;
    logic [7:0]    acc;
    ext = EW'(m);
    acc = 8'd0;
    for (int i = 0; i < EW / 2; i++) begin
      acc = acc + 8'(ext[2*i +: 2]);
    end
    acc = fold4(fold4(acc));
    if (acc >= 8'd3) acc = acc - 8'd3;
    if (acc >= 8'd3) acc = acc - 8'd3;
    return acc[1:0];
  endfunction

  assign unused_s = ^din_tdata[D_WIDTH-1:QW];

  // Lift into (-q/2, q/2] and reduce to a trit; a negative value with remainder r maps to p-r.
  always_comb begin
    v_s         = din_tdata[QW-1:0];
    neg_s       = (v_s > QW'(HALF));
    mag_s       = neg_s ? (~v_s + QW'(1)) : v_s;
    rem_s       = mod3(mag_s);
    trit_s      = (neg_s && (rem_s != 2'd0)) ? (2'(p) - rem_s) : rem_s;
    coef_inc_s  = coef_cnt_r + CW'(1);
    last_beat_s = (coef_inc_s == CW'(N));
    close_s     = din_tlast | last_beat_s;
    len_bad_s   = din_tlast ^ last_beat_s;
    accept_s    = din_tvalid & din_tready & (state_r == FILL);
    pack_ins_s  = pack_r | (D_WIDTH'(trit_s) << {slot_r, 1'b0});
  end

  // Fill/send state machine with registered stream outputs and sticky length error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= FILL;
      slot_r      <= '0;
      coef_cnt_r  <= '0;
      pack_r      <= '0;
      din_tready  <= 1'b0;
      dout_tdata  <= '0;
      dout_tvalid <= 1'b0;
      dout_tlast  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          din_tready <= 1'b1;
          if (accept_s) begin
            pack_r     <= pack_ins_s;
            slot_r     <= slot_r + SW'(1);
            coef_cnt_r <= coef_inc_s;
            frame_err  <= frame_err | len_bad_s;
            if (close_s || (slot_r == SW'(TPW - 1))) begin
              state_r     <= SEND;
              din_tready  <= 1'b0;
              dout_tvalid <= 1'b1;
              dout_tlast  <= close_s;
              dout_tdata  <= pack_ins_s;
            end
          end
        end
        SEND: begin
          if (dout_tready) begin
            state_r     <= FILL;
            din_tready  <= 1'b1;
            dout_tvalid <= 1'b0;
            dout_tlast  <= 1'b0;
            pack_r      <= '0;
            slot_r      <= '0;
            if (dout_tlast) coef_cnt_r <= '0;
          end
        end
        default: begin
          state_r <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntru_modp_pack.sv
// Bench for ntru_modp_pack: directed literal scenarios plus random frames on an
// N=11 and an N=20 instance, both checked every cycle against a trit-list model.
module tb_ntru_modp_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din_tdata   [2];
  logic [31:0] dout_tdata  [2];
  logic        din_tvalid  [2];
  logic        din_tlast   [2];
  logic        din_tready  [2];
  logic        dout_tvalid [2];
  logic        dout_tlast  [2];
  logic        dout_tready [2];
  logic        frame_err   [2];

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  always #5 clk = ~clk;

  ntru_modp_pack #(.D_WIDTH(32), .N(11), .q(2048), .p(3)) dut0 (
    .clk(clk), .reset(rst_n),
    .din_tdata(din_tdata[0]), .din_tvalid(din_tvalid[0]), .din_tlast(din_tlast[0]),
    .din_tready(din_tready[0]),
    .dout_tdata(dout_tdata[0]), .dout_tvalid(dout_tvalid[0]), .dout_tlast(dout_tlast[0]),
    .dout_tready(dout_tready[0]), .frame_err(frame_err[0]));

  ntru_modp_pack #(.D_WIDTH(32), .N(20), .q(2048), .p(3)) dut1 (
    .clk(clk), .reset(rst_n),
    .din_tdata(din_tdata[1]), .din_tvalid(din_tvalid[1]), .din_tlast(din_tlast[1]),
    .din_tready(din_tready[1]),
    .dout_tdata(dout_tdata[1]), .dout_tvalid(dout_tvalid[1]), .dout_tlast(dout_tlast[1]),
    .dout_tready(dout_tready[1]), .frame_err(frame_err[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nlen(input int d);
    return (d == 0) ? 11 : 20;
  endfunction

  // Center lift then mod 3 with plain integer arithmetic.
  function automatic int trit(input int v);
    int s;
    s = (v > 1024) ? v - 2048 : v;
    return ((s % 3) + 3) % 3;
  endfunction

  // Model: trits of the word being built, beats of the current frame, expected words.
  int          tr   [2][16];
  int          ntr  [2];
  int          cnt  [2];
  bit          exp_err [2];
  bit          lat  [2];
  bit          pv   [2];
  bit          pr   [2];
  logic [32:0] pw   [2];
  bit          rst_prev = 1'b0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  always @(negedge clk) begin : mon
    int          v;
    int          n;
    bit          close;
    bit          empty;
    logic [31:0] w;
    logic [32:0] e;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        ntr[d] = 0; cnt[d] = 0; exp_err[d] = 1'b0; lat[d] = 1'b0;
        if (d == 0) q0.delete(); else q1.delete();
      end else if (rst_prev) begin
        chk("reset_values", {din_tready[d], dout_tvalid[d], dout_tlast[d], frame_err[d], dout_tdata[d]}, 64'h0);
      end else begin
        chk("frame_err", frame_err[d], exp_err[d]);
        chk("ready_vs_valid", din_tready[d], !dout_tvalid[d]);
        if (lat[d]) chk("word_latency", dout_tvalid[d], 1'b1);
        lat[d] = 1'b0;
        if (pv[d] && !pr[d]) chk("hold", {dout_tvalid[d], dout_tlast[d], dout_tdata[d]}, {1'b1, pw[d]});
        if (dout_tvalid[d] && dout_tready[d]) begin
          empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
          if (empty) begin
            checks++; errors++;
            $display("FAIL unexpected_word dut%0d actual=%0h required=none at %0t", d, dout_tdata[d], $time);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("word", {dout_tlast[d], dout_tdata[d]}, e);
          end
        end
      end
      if (rst_n && din_tvalid[d] && din_tready[d]) begin
        v = int'(din_tdata[d][10:0]);
        tr[d][ntr[d]] = trit(v);
        ntr[d]++;
        cnt[d]++;
        n = nlen(d);
        close = din_tlast[d] || (cnt[d] == n);
        if (din_tlast[d] != (cnt[d] == n)) exp_err[d] = 1'b1;
        if (close || ntr[d] == 16) begin
          w = 32'h0;
          for (int k = 0; k < ntr[d]; k++) w = w | (32'(tr[d][k]) << (2 * k));
          if (d == 0) q0.push_back({close, w}); else q1.push_back({close, w});
          ntr[d] = 0;
          lat[d] = 1'b1;
          if (close) cnt[d] = 0;
        end
      end
      pv[d] = rst_n && dout_tvalid[d];
      pr[d] = dout_tready[d];
      pw[d] = {dout_tlast[d], dout_tdata[d]};
    end
    rst_prev = !rst_n;
  end

  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rdy_mode == 0) dout_tready[d] = 1'b1;
      else if (rdy_mode == 1) dout_tready[d] = (($urandom % 3) != 0);
    end
  end

  // Present one beat (called at posedge+1) and hold it until accepted.
  task automatic beat(input int d, input int v, input bit last);
    logic [31:0] x;
    bit ok;
    int k;
    x = $urandom;
    x[10:0] = v[10:0];
    din_tdata[d] = x; din_tvalid[d] = 1'b1; din_tlast[d] = last;
    ok = 1'b0; k = 0;
    while (!ok && k < 200) begin
      @(negedge clk);
      ok = din_tready[d] && rst_n;
      @(posedge clk); #1;
      k++;
    end
    chk("beat_accepted", ok, 1'b1);
    din_tvalid[d] = 1'b0; din_tlast[d] = 1'b0;
  endtask

  task automatic wait_word(input int d, input logic [31:0] ed, input bit el, input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!dout_tvalid[d] && k < 50);
    chk({name, "_valid"}, dout_tvalid[d], 1'b1);
    chk({name, "_data"}, dout_tdata[d], ed);
    chk({name, "_last"}, dout_tlast[d], el);
    @(posedge clk); #1;
  endtask

  task automatic frame1(input int d, input int nb);
    int vals[11];
    vals = '{1, 2047, 0, 2, 1024, 1025, 2046, 3, 4, 5, 2047};
    for (int i = 0; i < nb; i++) beat(d, vals[i], i == 10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_run(input int d);
    int len, v, sel;
    bit drop;
    for (int f = 0; f < 30; f++) begin
      len  = $urandom_range(1, nlen(d) + 4);
      drop = (($urandom % 5) == 0);
      for (int i = 0; i < len; i++) begin
        sel = $urandom % 6;
        v = (sel == 0) ? 0 : (sel == 1) ? 1024 : (sel == 2) ? 1025 : (sel == 3) ? 2047 : int'($urandom % 2048);
        beat(d, v, (i == len - 1) && !drop);
        if (($urandom % 4) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      din_tdata[d] = 32'h0; din_tvalid[d] = 1'b0; din_tlast[d] = 1'b0; dout_tready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    frame1(0, 11);
    wait_word(0, 32'h00291189, 1'b1, "s1");
    chk("s1_err", frame_err[0], 1'b0);

    for (int i = 0; i < 20; i++) begin
      beat(1, 1, i == 19);
      if (i == 15) wait_word(1, 32'h55555555, 1'b0, "s2_w0");
    end
    wait_word(1, 32'h00000055, 1'b1, "s2_w1");

    rdy_mode = 2;
    dout_tready[0] = 1'b0;
    frame1(0, 11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_data", dout_tdata[0], 32'h00291189);
      chk("bp_valid", dout_tvalid[0], 1'b1);
      chk("bp_in_ready", din_tready[0], 1'b0);
    end
    @(posedge clk); #1;
    dout_tready[0] = 1'b1;
    @(negedge clk);
    chk("bp_accept", {dout_tvalid[0], dout_tlast[0], dout_tdata[0]}, {2'b11, 32'h00291189});
    @(negedge clk);
    chk("bp_resume", {din_tready[0], dout_tvalid[0]}, 2'b10);
    @(posedge clk); #1;
    rdy_mode = 0;

    for (int i = 0; i < 5; i++) beat(0, 2047, i == 4);
    wait_word(0, 32'h000002AA, 1'b1, "s4");
    chk("s4_err", frame_err[0], 1'b1);
    frame1(0, 11);
    wait_word(0, 32'h00291189, 1'b1, "s4_next");

    do_reset();
    @(negedge clk);
    chk("s5_err_clear", frame_err[0], 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 11; i++) beat(0, 1024, 1'b0);
    wait_word(0, 32'h00155555, 1'b1, "s5");
    chk("s5_err", frame_err[0], 1'b1);

    frame1(0, 6);
    do_reset();
    @(negedge clk);
    chk("s6_after_reset", {dout_tvalid[0], frame_err[0]}, 2'b00);
    @(posedge clk); #1;
    frame1(0, 11);
    wait_word(0, 32'h00291189, 1'b1, "s6");

    rdy_mode = 1;
    fork
      rand_run(0);
      rand_run(1);
    join
    rdy_mode = 0;
    repeat (50) @(posedge clk);
    #1;
    chk("drain0", q0.size(), 0);
    chk("drain1", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntru_modp_pack.md
Name: ntru_modp_pack

Overview:
- Downstream of the NTRU serial multiplier AXI4-Stream IP; consumes its coefficient output stream (e = h*r + m mod q, one coefficient per beat, value in din_tdata[QW-1:0]).
- Center-lifts each coefficient from [0,q-1] to (-q/2, q/2], reduces it mod p to a trit, and packs trits 2 bits each into D_WIDTH-bit AXI4-Stream words for the decryption/host path.
- Frame length is checked against N.

Parameters:
- D_WIDTH, 32, stream data width on both sides; must be even.
- N, 11, coefficients per frame (polynomial degree).
- q, 2048, modulus of incoming coefficients; power of two. QW = clog2(q-1) = 11 LSBs are used.
- p, 3, reduction modulus; trit codes fit in 2 bits.
- Derived: TPW = D_WIDTH/2 = 16 trits per output word.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- din_tdata  in  D_WIDTH  coefficient in [QW-1:0]; upper bits ignored
- din_tvalid  in  1  input beat valid
- din_tlast  in  1  last coefficient of frame
- din_tready  out  1  block can accept a beat
- dout_tdata  out  D_WIDTH  packed trits; slot k at bits [2k+1:2k]
- dout_tvalid  out  1  output word valid
- dout_tlast  out  1  word closes the frame
- dout_tready  in  1  downstream accepts word
- frame_err  out  1  sticky frame-length error

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=FILL; slot=0; coef_cnt=0; pack register=0.
  - dout_tvalid=0, dout_tlast=0, dout_tdata=0, frame_err=0, din_tready=0 during the reset cycle.
  - Reset mid-frame or mid-handshake discards all partial data; no word is emitted.
- Arithmetic per accepted beat, v = din_tdata[QW-1:0]:
  - Lift: s = v if v <= q/2, else s = v - q (signed, QW+1 bits).
  - t = ((s mod p) + p) mod p, in {0,1,2}.
  - Encoding: 2'b00=0, 2'b01=+1, 2'b10=2 (≡ -1); 2'b11 is never produced.
  - Reduction is combinational within the accept cycle; no multipliers; a constant-divisor or lookup implementation is allowed.
- FSM FILL:
  - din_tready=1, dout_tvalid=0.
  - On din_tvalid&din_tready: write t into pack slot `slot`, slot++, coef_cnt++.
  - Frame closes if din_tlast=1 or coef_cnt+1==N.
  - Move to SEND if slot==TPW-1 or the frame closes.
  - Entering SEND registers dout_tvalid=1 and dout_tlast=(frame closes), with dout_tdata = the pack register including the new trit.
  - Latency: word valid the cycle after the final contributing beat.
- FSM SEND:
  - din_tready=0.
  - dout_tdata and dout_tlast are held stable while dout_tvalid=1 and dout_tready=0.
  - On dout_tready: dout_tvalid=0, pack register=0, slot=0, state=FILL.
  - If the word had tlast, coef_cnt=0.
- Partial word: unused slots are 0. Words per well-formed frame = ceil(N/TPW).
- Frame check, evaluated on the closing beat:
  - frame_err set if din_tlast=1 with coef_cnt+1<N (early tlast).
  - frame_err set if coef_cnt+1==N with din_tlast=0 (missing tlast).
  - Frame closes in both cases; the next beat starts a new frame at slot 0.
  - frame_err is cleared only by reset.
- Throughput: TPW input beats plus at least 1 output cycle per word; no overlap of FILL and SEND.
- din_tvalid with din_tready=0 is ignored; the upstream holds the data per AXI4-Stream rules.

Test Plan:
- N=11 frame v = 1,2047,0,2,1024,1025,2046,3,4,5,2047, tlast on beat 11 -> trits 1,2,0,2,1,0,1,0,1,2,2; one word 0x00291189 with dout_tlast=1 one cycle after beat 11; frame_err=0.
- N=20, all v=1, tlast on beat 20 -> word0 0x55555555 with tlast=0, then word1 0x00000055 with tlast=1; din_tready=0 only during SEND.
- Backpressure: hold dout_tready=0 for 5 cycles on the first-scenario word -> dout_tdata stays 0x00291189, dout_tvalid=1, din_tready=0 throughout; the word is accepted on the 6th cycle and FILL resumes the next cycle.
- Early tlast (N=11): v = 2047 x5, tlast on beat 5 -> word 0x000002AA with tlast=1; frame_err=1; a following correct frame is packed from slot 0.
- Missing tlast (N=11): 11 beats v=1024, tlast=0 -> word 0x00155555 with tlast=1; frame_err=1.
- Reset mid-frame: 6 beats accepted, then reset=0 for 1 cycle -> no output; frame_err=0; the first-scenario frame then yields 0x00291189 with tlast=1.
